// File: rtl/rv_fetch_pkg.sv
// Shared types and helpers for the rv32im instruction-fetch stage.
// Holds the bubble encoding, the fetch FSM states and the redirect arbiter.
package rv_fetch_pkg;

   localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      StBoot,
      StIssue,
      StWait,
      StDrop
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] target;
   } redirect_t;

   // jalr beats branch beats jal; targets are forced word-aligned
   function automatic redirect_t pick_redirect(
      input logic        jalr,
      input logic [31:0] jalr_target,
      input logic        branch,
      input logic [31:0] branch_target,
      input logic        jal,
      input logic [31:0] jal_target
   );
      redirect_t r;
      r.valid = jalr | branch | jal;
      if (jalr) begin
         r.target = jalr_target;
      end else if (branch) begin
         r.target = branch_target;
      end else begin
         r.target = jal_target;
      end
      r.target[1:0] = 2'b00;
      return r;
   endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry skid buffer holding a fetched {pc, instruction} while IF/ID is stalled.
// Flush beats load; load beats drain.
module fetch_hold_reg
   import rv_fetch_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic        i_drain,
   input  logic        i_flush,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr
);

   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_instr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_pc    <= 32'h0;
         r_instr <= RV_NOP_INSTR;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_instr <= i_instr;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// rv32im instruction-fetch stage: owns the PC, issues one imem request at a time,
// feeds IF/ID through an output register plus a one-entry skid, and handles redirects.
module fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        next_select,
   input  logic [31:0] jal_target,
   input  logic        branch_result,
   input  logic [31:0] branch_target,
   input  logic        jalr,
   input  logic [31:0] jalr_target,
   input  logic        load,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] pre_address_pc,
   output logic [31:0] instruction_fetch,
   output logic        fetch_valid
);

   fetch_state_e r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic [31:0]  r_req_pc, w_req_pc_nxt;
   logic [31:0]  r_out_pc, w_out_pc_nxt;
   logic [31:0]  r_out_instr, w_out_instr_nxt;
   logic         r_out_valid, w_out_valid_nxt;

   logic         w_skid_valid, w_skid_load, w_skid_drain, w_skid_flush;
   logic [31:0]  w_skid_pc, w_skid_instr;
   redirect_t    w_redir;
   logic         w_handshake, w_rsp_wait, w_out_load;

   fetch_hold_reg u_hold (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_load  (w_skid_load),
      .i_drain (w_skid_drain),
      .i_flush (w_skid_flush),
      .i_pc    (r_req_pc),
      .i_instr (imem_rsp_data),
      .o_valid (w_skid_valid),
      .o_pc    (w_skid_pc),
      .o_instr (w_skid_instr)
   );

   assign w_redir     = pick_redirect(jalr, jalr_target, branch_result, branch_target,
                                      next_select, jal_target);
   assign w_handshake = (r_state == StIssue) && !w_skid_valid && imem_req_ready;
   assign w_rsp_wait  = (r_state == StWait) && imem_rsp_valid;
   assign w_out_load  = !load || !r_out_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StBoot;
         r_pc        <= RESET_PC;
         r_req_pc    <= RESET_PC;
         r_out_pc    <= 32'h0;
         r_out_instr <= NOP_INSTR;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_req_pc    <= w_req_pc_nxt;
         r_out_pc    <= w_out_pc_nxt;
         r_out_instr <= w_out_instr_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_req_pc_nxt    = r_req_pc;
      w_out_pc_nxt    = r_out_pc;
      w_out_instr_nxt = r_out_instr;
      w_out_valid_nxt = r_out_valid;
      w_skid_load     = 1'b0;
      w_skid_drain    = 1'b0;
      w_skid_flush    = 1'b0;

      if (w_handshake) begin
         w_req_pc_nxt = r_pc;
         w_pc_nxt     = r_pc + 32'd4;
      end

      unique case (r_state)
         StBoot:  w_state_nxt = StIssue;
         StIssue: if (w_handshake) w_state_nxt = StWait;
         StWait:  if (imem_rsp_valid) w_state_nxt = StIssue;
         StDrop:  if (imem_rsp_valid) w_state_nxt = StIssue;
         default: w_state_nxt = StIssue;
      endcase

      if (w_redir.valid) begin
         w_pc_nxt        = w_redir.target;
         w_out_pc_nxt    = 32'h0;
         w_out_instr_nxt = NOP_INSTR;
         w_out_valid_nxt = 1'b0;
         w_skid_flush    = 1'b1;
         // Any request still in flight after this edge returns stale data
         if (((r_state == StWait || r_state == StDrop) && !imem_rsp_valid) || w_handshake) begin
            w_state_nxt = StDrop;
         end else begin
            w_state_nxt = StIssue;
         end
      end else if (w_out_load) begin
         if (w_skid_valid) begin
            w_out_pc_nxt    = w_skid_pc;
            w_out_instr_nxt = w_skid_instr;
            w_out_valid_nxt = 1'b1;
            w_skid_drain    = 1'b1;
         end else if (w_rsp_wait) begin
            w_out_pc_nxt    = r_req_pc;
            w_out_instr_nxt = imem_rsp_data;
            w_out_valid_nxt = 1'b1;
         end else begin
            w_out_pc_nxt    = 32'h0;
            w_out_instr_nxt = NOP_INSTR;
            w_out_valid_nxt = 1'b0;
         end
      end else if (w_rsp_wait) begin
         w_skid_load = 1'b1;
      end
   end

   assign imem_req_valid    = (r_state == StIssue) && !w_skid_valid;
   assign imem_req_addr     = r_pc;
   assign pre_address_pc    = r_out_pc;
   assign instruction_fetch = r_out_instr;
   assign fetch_valid       = r_out_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for streaming, stall and skid,
// then hand sequences for redirects, PC wrap and asynchronous reset.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        next_select, branch_result, jalr, load;
   logic [31:0] jal_target, branch_target, jalr_target;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] pre_address_pc, instruction_fetch;
   logic        fetch_valid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk               (clk),
      .rst               (rst),
      .next_select       (next_select),
      .jal_target        (jal_target),
      .branch_result     (branch_result),
      .branch_target     (branch_target),
      .jalr              (jalr),
      .jalr_target       (jalr_target),
      .load              (load),
      .imem_req_valid    (imem_req_valid),
      .imem_req_ready    (imem_req_ready),
      .imem_req_addr     (imem_req_addr),
      .imem_rsp_valid    (imem_rsp_valid),
      .imem_rsp_data     (imem_rsp_data),
      .pre_address_pc    (pre_address_pc),
      .instruction_fetch (instruction_fetch),
      .fetch_valid       (fetch_valid)
   );

   // Inputs apply to the cycle in which the expected outputs are observed
   typedef struct packed {
      logic        ready;
      logic        rsp_v;
      logic [31:0] rsp_d;
      logic        ld;
      logic        e_rv;
      logic [31:0] e_ra;
      logic        e_fv;
      logic [31:0] e_pc;
      logic [31:0] e_in;
   } vec_t;

   vec_t vec [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic rv, input logic [31:0] ra,
                             input logic fv, input logic [31:0] pc, input logic [31:0] ins);
      check({tag, ".req_valid"}, 32'(imem_req_valid), 32'(rv));
      check({tag, ".req_addr"}, imem_req_addr, ra);
      check({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(fv));
      check({tag, ".pc"}, pre_address_pc, pc);
      check({tag, ".instr"}, instruction_fetch, ins);
   endtask

   task automatic drive(input logic ready, input logic rsp_v, input logic [31:0] rsp_d,
                        input logic ld);
      imem_req_ready = ready;
      imem_rsp_valid = rsp_v;
      imem_rsp_data  = rsp_d;
      load           = ld;
   endtask

   task automatic clear_redirects();
      next_select   = 1'b0;
      branch_result = 1'b0;
      jalr          = 1'b0;
   endtask

   initial begin
      //           rdy rsp  rsp_d          ld   rv  addr        fv  pc          instr
      vec[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h00, 1'b0, 32'h0,  NOP};
      vec[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h00, 1'b0, 32'h0,  NOP};
      vec[2]  = '{1'b0, 1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h04, 1'b0, 32'h0,  NOP};
      vec[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h04, 1'b1, 32'h0,  32'h1111_0000};
      vec[4]  = '{1'b0, 1'b1, 32'h2222_0004, 1'b0, 1'b0, 32'h08, 1'b0, 32'h0,  NOP};
      vec[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h08, 1'b1, 32'h4,  32'h2222_0004};
      vec[6]  = '{1'b0, 1'b1, 32'h3333_0008, 1'b0, 1'b0, 32'h0C, 1'b0, 32'h0,  NOP};
      vec[7]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0C, 1'b1, 32'h8,  32'h3333_0008};
      vec[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0C, 1'b0, 32'h0,  NOP};
      vec[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0C, 1'b0, 32'h0,  NOP};
      vec[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0C, 1'b0, 32'h0,  NOP};
      vec[11] = '{1'b0, 1'b1, 32'h4444_000C, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0,  NOP};
      vec[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10, 1'b1, 32'hC,  32'h4444_000C};
      vec[13] = '{1'b0, 1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 32'h14, 1'b1, 32'hC,  32'h4444_000C};
      vec[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h14, 1'b1, 32'hC,  32'h4444_000C};
      vec[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h14, 1'b1, 32'h10, 32'hAAAA_0001};
      vec[16] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h14, 1'b0, 32'h0,  NOP};

      rst = 1'b1;
      clear_redirects();
      jal_target    = 32'h0;
      branch_target = 32'h0;
      jalr_target   = 32'h0;
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (2) @(negedge clk);
      check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         check_outs($sformatf("vec%0d", i), vec[i].e_rv, vec[i].e_ra, vec[i].e_fv,
                    vec[i].e_pc, vec[i].e_in);
         drive(vec[i].ready, vec[i].rsp_v, vec[i].rsp_d, vec[i].ld);
         @(negedge clk);
      end

      // jalr while a request at 0x14 is outstanding: stale response must be dropped
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check_outs("wait14", 1'b0, 32'h18, 1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      jalr = 1'b1;
      jalr_target = 32'h0000_0103;
      @(negedge clk);
      check_outs("jalr_drop", 1'b0, 32'h100, 1'b0, 32'h0, NOP);
      clear_redirects();
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      check_outs("stale_gone", 1'b1, 32'h100, 1'b0, 32'h0, NOP);

      // Fetch 0x100, then all three redirects with load=1: jalr wins, bubble anyway
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h5555_0100, 1'b0);
      @(negedge clk);
      check_outs("got100", 1'b1, 32'h104, 1'b1, 32'h100, 32'h5555_0100);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      next_select = 1'b1;
      jal_target = 32'h200;
      branch_result = 1'b1;
      branch_target = 32'h300;
      jalr = 1'b1;
      jalr_target = 32'h400;
      @(negedge clk);
      check_outs("prio", 1'b1, 32'h400, 1'b0, 32'h0, NOP);

      // Redirect in the same cycle as a handshake: accepted request becomes stale
      clear_redirects();
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      next_select = 1'b1;
      jal_target = 32'h200;
      @(negedge clk);
      check_outs("hs_redir", 1'b0, 32'h200, 1'b0, 32'h0, NOP);
      clear_redirects();
      drive(1'b0, 1'b1, 32'hBAD0_0400, 1'b0);
      @(negedge clk);
      check_outs("hs_drop", 1'b1, 32'h200, 1'b0, 32'h0, NOP);

      // Misaligned jal target is aligned; PC wraps past 0xFFFF_FFFC
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      next_select = 1'b1;
      jal_target = 32'hFFFF_FFFE;
      @(negedge clk);
      check_outs("top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP);
      clear_redirects();
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check_outs("wrap", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      drive(1'b0, 1'b1, 32'h7777_0000, 1'b0);
      @(negedge clk);
      check_outs("got_top", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h7777_0000);
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check_outs("hold_wait", 1'b0, 32'h4, 1'b1, 32'hFFFF_FFFC, 32'h7777_0000);

      // Asynchronous reset mid-WAIT, away from any clock edge
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      #2 rst = 1'b1;
      #1 check_outs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      @(negedge clk);
      rst = 1'b0;
      check_outs("boot2", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      @(negedge clk);
      check_outs("issue2", 1'b1, 32'h0, 1'b0, 32'h0, NOP);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the rv32im pipeline, directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues one instruction-memory request at a time over a valid/ready request channel with a variable-latency response.
- Presents {pre_address_pc, instruction_fetch} to IF/ID, honours load-use stalls, and redirects on jal/branch/jalr, discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- next_select  in  1  jal taken; redirect to jal_target.
- jal_target  in  32  jal destination.
- branch_result  in  1  branch taken; redirect to branch_target.
- branch_target  in  32  branch destination.
- jalr  in  1  jalr taken; redirect to jalr_target.
- jalr_target  in  32  jalr destination.
- load  in  1  load-use stall; IF/ID is not sampling this cycle.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address (bits [1:0] always 0).
- imem_rsp_valid  in  1  response data valid; there is no backpressure on responses.
- imem_rsp_data  in  32  fetched instruction.
- pre_address_pc  out  32  PC of the presented instruction.
- instruction_fetch  out  32  presented instruction, or NOP_INSTR on a bubble.
- fetch_valid  out  1  presented instruction is real.

Behaviour:
- Reset (rst=1, async):
  - pc=RESET_PC, state=BOOT, skid empty.
  - Outputs: pre_address_pc=0, instruction_fetch=NOP_INSTR, fetch_valid=0, imem_req_valid=0, imem_req_addr=RESET_PC.
  - Reset mid-transaction abandons everything; the memory must drop any outstanding response on rst.
- States:
  - BOOT: one cycle, then ISSUE.
  - ISSUE: imem_req_valid = !skid_valid; imem_req_addr = pc.
  - WAIT: one request outstanding; imem_req_valid=0.
  - DROP: outstanding response is stale; imem_req_valid=0.
- Handshake (ISSUE, valid && ready):
  - req_pc <= pc; pc <= pc+4 (mod 2^32, wraps to 0); state goes to WAIT.
  - Address is stable while valid && !ready, except on redirect (the request was not accepted, so it may be retargeted).
- At most one outstanding request, always.
- WAIT with imem_rsp_valid:
  - If the output register can load: out <= {req_pc, data, valid=1}.
  - Otherwise: skid <= {req_pc, data}.
  - Either way, state goes to ISSUE.
- DROP with imem_rsp_valid: discard the data; state goes to ISSUE.
- Output register load condition: (load==0) || (fetch_valid==0).
  - When it loads, the source priority is: skid (if valid) > in-cycle WAIT response > bubble {pc 0, NOP_INSTR, valid 0}.
  - When load=1 and fetch_valid=1, the outputs hold unchanged.
- Latency: request accepted at cycle N, response at N+k (k>=1), output visible at cycle N+k+1. Zero-wait memory gives one instruction per 2 cycles.
- Redirect (any of next_select / branch_result / jalr), evaluated at the clock edge:
  - Priority: jalr > branch_result > next_select. The target has [1:0] forced to 0.
  - pc <= target; output becomes a bubble; skid cleared. Redirect overrides load.
  - Next state:
    - DROP if a request is outstanding after this edge (WAIT without rsp this cycle, or an ISSUE handshake this same cycle).
    - DROP stays DROP.
    - ISSUE otherwise (ISSUE unaccepted, or WAIT with rsp this cycle, whose data is discarded).
- Response outside WAIT/DROP: protocol error; ignored.

Decomposition:
- Package rv_fetch_pkg: NOP_INSTR constant, state encodings BOOT/ISSUE/WAIT/DROP, redirect-priority helper function.
- One natural sub-module: fetch_hold_reg (1-entry skid: valid, pc, instruction; load/drain/flush controls).
- The FSM and the output register stay in fetch_unit.

Test Plan:
- Reset release, ready=1, 1-cycle response, no stalls -> addresses 0x0, 0x4, 0x8; fetch_valid pulses every 2nd cycle with matching pc/data.
- Hold ready=0 for 3 cycles -> req_valid held high, addr=0x4 stable, pc unchanged; advances to 0x8 only after the handshake.
- Response 0xAAAA_0001 at pc 0x8 arrives while load=1 and out valid (pc 0x4) -> out holds 0x4 and skid captures 0x8; next cycle with load=0 presents 0x8; req_valid stays 0 until the skid drains.
- jalr=1 with jalr_target=0x103 while WAIT outstanding at 0x10 -> bubble, state DROP; the 0x10 response is discarded; next request addr=0x100.
- next_select, branch_result, jalr asserted together with targets 0x200/0x300/0x400 plus load=1 -> next addr=0x400; bubble presented despite load.
- pc=0xFFFF_FFFC handshake -> next address 0x0000_0000. Assert rst during WAIT -> all outputs return to reset values immediately.
